router_sync_n: RTL and testbench
================================

ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 Parameter NUM_CH, default 3: number of destination FIFOs/channels, range 2..8.
REQ-002 Parameter ADDR_W, default 2: address field width; SHALL satisfy 2^ADDR_W >= NUM_CH.
REQ-003 Parameter TIMEOUT, default 30: unread-packet timeout in clock edges, range 2..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 5: timeout counter width.
REQ-005 Reset rst, synchronous, active-low; clock clk.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-low reset.
REQ-008 detect_add  in  1  header cycle; latch destination address.
REQ-009 data_in  in  ADDR_W  destination address from header byte.
REQ-010 wrt_enb_reg  in  1  FSM request to write current byte.
REQ-011 rd_en  in  NUM_CH  per-channel FIFO read enable.
REQ-012 empty  in  NUM_CH  per-channel FIFO empty.
REQ-013 full  in  NUM_CH  per-channel FIFO full.
REQ-014 wrt_enb  out  NUM_CH  one-hot FIFO write enable.
REQ-015 fifo_full  out  1  full flag of addressed FIFO.
REQ-016 vld_out  out  NUM_CH  per-channel data valid.
REQ-017 sft_rst  out  NUM_CH  per-channel one-cycle soft-reset pulse.
REQ-018 addr_err  out  1  latched address is >= NUM_CH.
REQ-019 wr_drop  out  1  one-cycle pulse: write requested while addressed FIFO full.

Function
REQ-020 Address register SHALL load data_in on the rising edge where detect_add=1; otherwise hold.
REQ-021 addr_err SHALL be combinational from the address register: 1 iff address >= NUM_CH.
REQ-022 wrt_enb SHALL be combinational: bit[addr]=1 iff wrt_enb_reg=1 and addr_err=0 and full[addr]=0; otherwise all zeros.
REQ-023 fifo_full SHALL equal full[addr] when addr_err=0, else 0.
REQ-024 detect_add and wrt_enb_reg in the same cycle: wrt_enb SHALL use the previously latched address.
REQ-025 wr_drop SHALL be registered: 1 for one cycle after an edge with wrt_enb_reg=1, addr_err=0, full[addr]=1.
REQ-026 vld_out[i] SHALL equal !empty[i], combinationally.
REQ-027 Per channel, counter SHALL load 1 and sft_rst[i] SHALL go 0 at any edge with vld_out[i]=0 or rd_en[i]=1.
REQ-028 Otherwise, when counter==TIMEOUT: sft_rst[i]<=1 for one cycle and counter<=1; else counter increments, sft_rst[i]<=0.
REQ-029 Hence sft_rst[i] rises at the TIMEOUT-th consecutive edge with vld_out[i]=1 and rd_en[i]=0, and repeats every TIMEOUT edges while stalled.
REQ-030 Priority per channel: reset > !vld_out > rd_en > timeout > increment; counter SHALL never wrap.
REQ-031 Channels SHALL be fully independent; simultaneous timeouts on multiple channels SHALL pulse concurrently.

Reset
REQ-032 With rst=0 at an edge: address<=0, all counters<=1, sft_rst<=0, wr_drop<=0.
REQ-033 During reset wrt_enb SHALL be 0 unless wrt_enb_reg=1; reset mid-count SHALL discard partial timeout progress.

Structure
REQ-034 Package router_pkg SHALL hold the default NUM_CH, TIMEOUT, ADDR_W and a counter-width helper constant.
REQ-035 Sub-module router_sft_rst_timer (one channel: vld, rd_en -> sft_rst) SHALL be instantiated NUM_CH times via generate.
REQ-036 Address latch, decode, fifo_full mux and wr_drop SHALL reside in the top module.

Verification
REQ-037 NUM_CH=3: detect_add with data_in=1, then wrt_enb_reg=1 -> wrt_enb=3'b010; full[1]=1 -> fifo_full=1, wrt_enb=0, wr_drop pulses once.
REQ-038 data_in=3 latched -> addr_err=1, wrt_enb=0, fifo_full=0 regardless of full inputs.
REQ-039 empty[0]=0, rd_en[0]=0 held -> sft_rst[0] high exactly 1 cycle after the 30th edge, again after 60th; other channels stay 0.
REQ-040 Same as REQ-039 with rd_en[0]=1 at edge 29 -> no sft_rst[0]; counting restarts from 1.
REQ-041 rst=0 at edge 15 of a stall -> counter restarts; sft_rst[0] rises 30 edges after rst release, not earlier.
REQ-042 NUM_CH=5, TIMEOUT=4, ADDR_W=3: data_in=4 -> wrt_enb=5'b10000; stalled channels 2 and 4 pulse sft_rst together every 4 edges.

Source files
------------

// File: rtl/router_pkg.sv
// Shared defaults for the router synchronizer and its per-channel timeout timer.
package router_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int ADDR_W_DEF  = 2;
  localparam int TIMEOUT_DEF = 30;

  // Smallest width that can hold max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

  localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/router_sft_rst_timer.sv
// One channel's unread-packet watchdog: pulses sft_rst every TIMEOUT edges of
// valid data that nobody reads.
module router_sft_rst_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic rd_en,
  output logic sft_rst
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Counter restarts at 1 so the TIMEOUT-th stalled edge sees cnt == TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= CNT_ONE;
      sft_rst <= 1'b0;
    end else if (!vld || rd_en) begin
      cnt     <= CNT_ONE;
      sft_rst <= 1'b0;
    end else if (cnt == CNT_TC) begin
      cnt     <= CNT_ONE;
      sft_rst <= 1'b1;
    end else begin
      cnt     <= cnt + CNT_ONE;
      sft_rst <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// Router synchronizer: latches the header address, steers the FIFO write
// enable, flags dropped writes and runs one soft-reset watchdog per channel.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              wrt_enb_reg,
  input  logic [NUM_CH-1:0] rd_en,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] wrt_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] sft_rst,
  output logic              addr_err,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= '0;
    end else if (detect_add) begin
      addr <= data_in;
    end
  end

  assign addr_err = ({1'b0, addr} >= NUM_CH_EXT);

  // An out-of-range address matches no channel, so enable and full stay 0.
  always_comb begin
    wrt_enb   = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ADDR_W'(i)) begin
        fifo_full  = full[i];
        wrt_enb[i] = wrt_enb_reg & ~full[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wrt_enb_reg & fifo_full;
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sft_rst_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .vld     (vld_out[g]),
      .rd_en   (rd_en[g]),
      .sft_rst (sft_rst[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Random plus directed bench for router_sync_n at the default and a 5-channel
// configuration, checked against a run-length behavioural model.
module tb_router_sync_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       det  [2];
  logic       wreg [2];
  logic [2:0] din  [2];
  logic [7:0] rd   [2];
  logic [7:0] emp  [2];
  logic [7:0] ful  [2];

  logic [2:0] wen_a, vld_a, sft_a;
  logic       ff_a, err_a, drop_a;
  logic [4:0] wen_b, vld_b, sft_b;
  logic       ff_b, err_b, drop_b;

  always #5 clk = ~clk;

  router_sync_n dut_a (
    .clk         (clk),
    .rst         (rst),
    .detect_add  (det[0]),
    .data_in     (din[0][1:0]),
    .wrt_enb_reg (wreg[0]),
    .rd_en       (rd[0][2:0]),
    .empty       (emp[0][2:0]),
    .full        (ful[0][2:0]),
    .wrt_enb     (wen_a),
    .fifo_full   (ff_a),
    .vld_out     (vld_a),
    .sft_rst     (sft_a),
    .addr_err    (err_a),
    .wr_drop     (drop_a)
  );

  router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .detect_add  (det[1]),
    .data_in     (din[1]),
    .wrt_enb_reg (wreg[1]),
    .rd_en       (rd[1][4:0]),
    .empty       (emp[1][4:0]),
    .full        (ful[1][4:0]),
    .wrt_enb     (wen_b),
    .fifo_full   (ff_b),
    .vld_out     (vld_b),
    .sft_rst     (sft_b),
    .addr_err    (err_b),
    .wr_drop     (drop_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: address, pending drop flag and per-channel stall run length.
  int nch [2] = '{3, 5};
  int tmo [2] = '{30, 4};
  int aw  [2] = '{2, 3};
  int m_addr [2];
  bit m_drop [2];
  int run    [2][8];
  bit m_sft  [2][8];

  bit       rand_en  = 1'b1;
  bit       rst_rand = 1'b0;
  logic [7:0] stall_mask [2] = '{8'h00, 8'h00};
  logic [7:0] rd_force   [2] = '{8'h00, 8'h00};

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_addr[d] = 0;
        m_drop[d] = 1'b0;
        for (int c = 0; c < 8; c++) begin
          run[d][c]   = 0;
          m_sft[d][c] = 1'b0;
        end
      end else begin
        m_drop[d] = wreg[d] && (m_addr[d] < nch[d]) && ful[d][m_addr[d]];
        if (det[d]) m_addr[d] = int'(din[d]);
        for (int c = 0; c < nch[d]; c++) begin
          if (emp[d][c] || rd[d][c]) begin
            run[d][c]   = 0;
            m_sft[d][c] = 1'b0;
          end else begin
            run[d][c]++;
            m_sft[d][c] = (run[d][c] % tmo[d]) == 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int a, e_wen, e_ff, e_sft, e_vld;
      bit e_err;
      a     = m_addr[d];
      e_err = a >= nch[d];
      e_ff  = e_err ? 0 : int'(ful[d][a]);
      e_wen = (!e_err && wreg[d] && !ful[d][a]) ? (1 << a) : 0;
      e_vld = int'(~emp[d]) & ((1 << nch[d]) - 1);
      e_sft = 0;
      for (int c = 0; c < nch[d]; c++) if (m_sft[d][c]) e_sft |= (1 << c);
      check_val($sformatf("wrt_enb%0d", d),   d ? int'(wen_b)  : int'(wen_a),  e_wen);
      check_val($sformatf("fifo_full%0d", d), d ? int'(ff_b)   : int'(ff_a),   e_ff);
      check_val($sformatf("addr_err%0d", d),  d ? int'(err_b)  : int'(err_a),  int'(e_err));
      check_val($sformatf("vld_out%0d", d),   d ? int'(vld_b)  : int'(vld_a),  e_vld);
      check_val($sformatf("sft_rst%0d", d),   d ? int'(sft_b)  : int'(sft_a),  e_sft);
      check_val($sformatf("wr_drop%0d", d),   d ? int'(drop_b) : int'(drop_a), int'(m_drop[d]));
    end
  endtask

  task automatic drive();
    if (rst_rand) rst = ($urandom_range(0, 40) != 0);
    for (int d = 0; d < 2; d++) begin
      det[d]  = ($urandom_range(0, 3) == 0);
      wreg[d] = 1'($urandom_range(0, 1));
      din[d]  = 3'($urandom_range(0, (1 << aw[d]) - 1));
      ful[d]  = 8'($urandom);
      emp[d]  = 8'($urandom) & ~stall_mask[d];
      rd[d]   = ((8'($urandom) & 8'($urandom)) & ~stall_mask[d]) | rd_force[d];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rand_en) drive();
    #1 check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset at the first cycle, then ncyc stalled edges; observes edge-by-edge.
  task automatic stall_run(input int ncyc, input int rd_at,
                           output int first, output int npulse, output int nboth);
    first = -1; npulse = 0; nboth = 0;
    rand_en = 1'b1; rst_rand = 1'b0;
    stall_mask[0] = 8'h01; stall_mask[1] = 8'h14;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      rd_force[0] = (k == rd_at) ? 8'h01 : 8'h00;
      cycle();
      if (sft_a[0]) begin
        npulse++;
        if (first < 0) first = k;
      end
      if (sft_b[2] && sft_b[4]) nboth++;
    end
    rd_force[0] = 8'h00;
  endtask

  initial begin
    int first, npulse, nboth;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      det[d] = 1'b0; wreg[d] = 1'b0; din[d] = '0;
      rd[d] = '0; emp[d] = 8'hff; ful[d] = '0;
    end
    rand_en = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check_val("rst_sft_a", int'(sft_a), 0);
    check_val("rst_drop_a", int'(drop_a), 0);
    check_val("rst_err_a", int'(err_a), 0);
    check_val("rst_sft_b", int'(sft_b), 0);

    // Header routing on the default configuration.
    rst = 1'b1;
    det[0] = 1'b1; din[0] = 3'd1;
    cycle();
    det[0] = 1'b0; wreg[0] = 1'b1;
    cycle();
    check_val("route1_wen", int'(wen_a), 3'b010);
    ful[0] = 8'h02;
    cycle();
    check_val("route1_full", int'(ff_a), 1);
    check_val("route1_wen_full", int'(wen_a), 0);
    check_val("route1_drop", int'(drop_a), 1);
    wreg[0] = 1'b0;
    cycle();
    check_val("route1_drop_once", int'(drop_a), 0);

    det[0] = 1'b1; din[0] = 3'd3;
    cycle();
    det[0] = 1'b0; wreg[0] = 1'b1; ful[0] = 8'h07;
    cycle();
    check_val("bad_addr_err", int'(err_a), 1);
    check_val("bad_addr_wen", int'(wen_a), 0);
    check_val("bad_addr_full", int'(ff_a), 0);

    det[1] = 1'b1; din[1] = 3'd4; wreg[1] = 1'b1; ful[1] = 8'h00;
    cycle();
    det[1] = 1'b0;
    cycle();
    check_val("ch4_wen", int'(wen_b), 5'b10000);

    // Fully random traffic including occasional resets.
    rand_en = 1'b1; rst_rand = 1'b1;
    repeat (600) cycle();
    rst_rand = 1'b0; rst = 1'b1;

    stall_run(65, -1, first, npulse, nboth);
    check_val("stall_first_pulse", first, 30);
    check_val("stall_pulses", npulse, 2);
    check_val("ch2_ch4_together", nboth, 16);

    stall_run(58, 29, first, npulse, nboth);
    check_val("read_restart_pulses", npulse, 0);

    stall_run(14, -1, first, npulse, nboth);
    stall_run(35, -1, first, npulse, nboth);
    check_val("rst_mid_first", first, 30);
    check_val("rst_mid_pulses", npulse, 1);

    stall_mask[0] = 8'h00; stall_mask[1] = 8'h00;
    rst_rand = 1'b1;
    repeat (400) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
